// File: rtl/p_i_cache_ctrl_nway_if.sv
// Handshake bundle between the I-cache controller (master) and the fetch stage,
// stage-2 datapath and physical-memory read port (slave).
interface p_i_cache_ctrl_nway_if #(
  parameter int WAYS = 4,
  parameter int SETS = 8
);
  localparam int IDX_W = $clog2(SETS);

  logic             mem_read;
  logic             mem_resp;
  logic             s2_valid;
  logic [WAYS-1:0]  s2_hit_vec;
  logic [WAYS-1:0]  s2_valid_vec;
  logic [WAYS-2:0]  s2_plru;
  logic             pmem_read;
  logic             pmem_resp;
  logic [WAYS-1:0]  way_load;
  logic             valid_datain;
  logic             lru_load;
  logic [WAYS-2:0]  lru_datain;
  logic             addr_sel;
  logic             flush_req;
  logic             flush_active;
  logic [IDX_W-1:0] flush_index;
  logic             flush_done;

  modport master (
    input  mem_read, s2_valid, s2_hit_vec, s2_valid_vec, s2_plru, pmem_resp, flush_req,
    output mem_resp, pmem_read, way_load, valid_datain, lru_load, lru_datain,
           addr_sel, flush_active, flush_index, flush_done
  );

  modport slave (
    output mem_read, s2_valid, s2_hit_vec, s2_valid_vec, s2_plru, pmem_resp, flush_req,
    input  mem_resp, pmem_read, way_load, valid_datain, lru_load, lru_datain,
           addr_sel, flush_active, flush_index, flush_done
  );
endinterface

// File: rtl/p_i_cache_ctrl_nway.sv
// WAYS-way read-only I-cache controller: hit/miss sequencing, line fill,
// tree-PLRU victim selection/update and an invalidate-all flush walk.
module p_i_cache_ctrl_nway #(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input logic                   clk,
  input logic                   rst,
  p_i_cache_ctrl_nway_if.master bus
);
  localparam int LW    = $clog2(WAYS);
  localparam int PW    = WAYS - 1;
  localparam int IDX_W = $clog2(SETS);

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, FILLED, FLUSH} state_t;

  state_t        state, state_nxt;
  logic          any_hit, lkp_hit, lkp_miss, flush_last;
  logic [LW-1:0] hit_way, victim_way;

  function automatic logic [LW-1:0] onehot_idx(input logic [WAYS-1:0] v);
    logic [LW-1:0] idx;
    idx = '0;
    for (int i = 0; i < WAYS; i++)
      if (v[i]) idx = LW'(i);
    return idx;
  endfunction

  // Invalid ways win; otherwise follow the tree (0 = left, 1 = right).
  function automatic logic [LW-1:0] pick_victim(input logic [WAYS-1:0] vv,
                                                input logic [PW-1:0]   p);
    logic [LW-1:0] idx;
    logic [PW-1:0] sh;
    int unsigned   n;
    idx = '0;
    n   = 0;
    if (&vv) begin
      for (int l = LW - 1; l >= 0; l--) begin
        sh = p >> n;
        if (sh[0]) begin
          idx[l] = 1'b1;
          n      = 2 * n + 2;
        end else begin
          n      = 2 * n + 1;
        end
      end
    end else begin
      for (int i = WAYS - 1; i >= 0; i--)
        if (!vv[i]) idx = LW'(i);
    end
    return idx;
  endfunction

  // Every node on the way's path is pointed away from it; other bits keep their value.
  function automatic logic [PW-1:0] plru_update(input logic [PW-1:0] old,
                                                input logic [LW-1:0] w);
    logic [PW-1:0] r;
    int unsigned   n;
    r = old;
    n = 0;
    for (int l = LW - 1; l >= 0; l--) begin
      if (w[l]) begin
        r = r & ~(PW'(1) << n);
        n = 2 * n + 2;
      end else begin
        r = r | (PW'(1) << n);
        n = 2 * n + 1;
      end
    end
    return r;
  endfunction

  assign any_hit    = |bus.s2_hit_vec;
  assign lkp_hit    = bus.s2_valid & bus.mem_read & any_hit;
  assign lkp_miss   = bus.s2_valid & bus.mem_read & ~any_hit;
  assign flush_last = (bus.flush_index == IDX_W'(SETS - 1));
  assign hit_way    = onehot_idx(bus.s2_hit_vec);
  assign victim_way = pick_victim(bus.s2_valid_vec, bus.s2_plru);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                 bus.flush_index <= '0;
    else if (state == FLUSH) bus.flush_index <= bus.flush_index + IDX_W'(1);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.flush_req)     state_nxt = FLUSH;
        else if (bus.mem_read) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        // A hit is served in this cycle even when a flush is pending.
        if (lkp_hit)            state_nxt = bus.flush_req ? FLUSH : LOOKUP;
        else if (lkp_miss)      state_nxt = MISS;
        else if (bus.flush_req) state_nxt = FLUSH;
        else if (!bus.mem_read) state_nxt = IDLE;
      end
      MISS:    if (bus.pmem_resp) state_nxt = FILLED;
      FILLED:  if (any_hit)       state_nxt = LOOKUP;
      FLUSH:   if (flush_last)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_resp     = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.way_load     = '0;
    bus.valid_datain = 1'b0;
    bus.lru_load     = 1'b0;
    bus.lru_datain   = '0;
    bus.addr_sel     = 1'b0;
    bus.flush_active = 1'b0;
    bus.flush_done   = 1'b0;
    unique case (state)
      LOOKUP: begin
        if (lkp_hit) begin
          bus.mem_resp   = 1'b1;
          bus.lru_load   = 1'b1;
          bus.lru_datain = plru_update(bus.s2_plru, hit_way);
        end
      end
      MISS: begin
        bus.addr_sel  = 1'b1;
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          bus.way_load     = WAYS'(1) << victim_way;
          bus.valid_datain = 1'b1;
        end
      end
      FILLED: begin
        bus.addr_sel = 1'b1;
        if (any_hit) begin
          bus.mem_resp   = bus.mem_read;
          bus.lru_load   = 1'b1;
          bus.lru_datain = plru_update(bus.s2_plru, hit_way);
        end
      end
      FLUSH: begin
        bus.flush_active = 1'b1;
        bus.way_load     = '1;
        bus.lru_load     = 1'b1;
        bus.flush_done   = flush_last;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_p_i_cache_ctrl_nway.sv
// Directed bench for p_i_cache_ctrl_nway: a 4-way and an 8-way instance with 8 sets each.
module tb_p_i_cache_ctrl_nway;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  p_i_cache_ctrl_nway_if #(.WAYS(4), .SETS(8)) a ();
  p_i_cache_ctrl_nway_if #(.WAYS(8), .SETS(8)) b ();

  p_i_cache_ctrl_nway #(.WAYS(4), .SETS(8)) dut_a (.clk(clk), .rst(rst), .bus(a));
  p_i_cache_ctrl_nway #(.WAYS(8), .SETS(8)) dut_b (.clk(clk), .rst(rst), .bus(b));

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    next_cycle();
    next_cycle();
    sample();
    n_cmp++;
    if ({a.mem_resp, a.pmem_read, a.way_load, a.valid_datain, a.lru_load, a.lru_datain,
         a.addr_sel, a.flush_active, a.flush_index, a.flush_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_a_outputs: got way_load=%b pmem_read=%b flush_index=%0d, required all zero",
               a.way_load, a.pmem_read, a.flush_index);
    end
    n_cmp++;
    if ({b.mem_resp, b.pmem_read, b.way_load, b.valid_datain, b.lru_load, b.lru_datain,
         b.addr_sel, b.flush_active, b.flush_index, b.flush_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_b_outputs: got way_load=%b lru_datain=%b, required all zero",
               b.way_load, b.lru_datain);
    end
    rst = 1'b0;
  endtask

  task automatic test_miss_plru();
    int cnt = 0;
    next_cycle();
    a.mem_read = 1'b1; a.s2_valid = 1'b0; a.s2_valid_vec = 4'hF; a.s2_plru = 3'b000;
    a.s2_hit_vec = 4'h0;
    sample();
    n_cmp++;
    if (a.mem_resp !== 1'b0) begin n_fail++; $display("FAIL idle_mem_resp: got %b required 0", a.mem_resp); end
    next_cycle();
    a.s2_valid = 1'b1;
    sample();
    n_cmp++;
    if ({a.pmem_read, a.addr_sel, a.mem_resp} !== 3'b000) begin
      n_fail++; $display("FAIL lookup_miss_outputs: got %b required 000", {a.pmem_read, a.addr_sel, a.mem_resp});
    end
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      a.s2_valid  = 1'b0;
      a.pmem_resp = (i == 4);
      sample();
      if (a.pmem_read === 1'b1) cnt++;
      n_cmp++;
      if (i < 4) begin
        if ({a.way_load, a.addr_sel} !== 5'b0000_1) begin
          n_fail++; $display("FAIL miss_wait_%0d: got way_load=%b addr_sel=%b required 0000/1", i, a.way_load, a.addr_sel);
        end
      end else if ({a.way_load, a.valid_datain} !== 5'b0001_1) begin
        n_fail++; $display("FAIL miss_fill_victim: got way_load=%b valid_datain=%b required 0001/1", a.way_load, a.valid_datain);
      end
    end
    n_cmp++;
    if (cnt !== 5) begin n_fail++; $display("FAIL miss_pmem_read_cycles: got %0d required 5", cnt); end
    next_cycle();
    a.pmem_resp = 1'b0; a.s2_valid = 1'b1; a.s2_hit_vec = 4'b0001;
    sample();
    n_cmp++;
    if ({a.mem_resp, a.lru_load, a.lru_datain, a.pmem_read} !== 6'b1_1_011_0) begin
      n_fail++; $display("FAIL filled_resp: got resp=%b lru_load=%b lru=%b pmem_read=%b required 1/1/011/0",
                         a.mem_resp, a.lru_load, a.lru_datain, a.pmem_read);
    end
    next_cycle();
    a.mem_read = 1'b0; a.s2_valid = 1'b0; a.s2_hit_vec = 4'h0;
    sample();
    n_cmp++;
    if (a.mem_resp !== 1'b0) begin n_fail++; $display("FAIL lookup_release: got %b required 0", a.mem_resp); end
  endtask

  task automatic test_victim_invalid();
    next_cycle();
    a.mem_read = 1'b1; a.s2_valid = 1'b0; a.s2_valid_vec = 4'b1011; a.s2_plru = 3'b111;
    next_cycle();
    a.s2_valid = 1'b1;
    next_cycle();
    a.s2_valid = 1'b0; a.pmem_resp = 1'b1;
    sample();
    n_cmp++;
    if (a.way_load !== 4'b0100) begin
      n_fail++; $display("FAIL invalid_victim: got way_load=%b required 0100", a.way_load);
    end
    next_cycle();
    a.pmem_resp = 1'b0; a.s2_valid = 1'b1; a.s2_hit_vec = 4'b0100;
    sample();
    n_cmp++;
    if ({a.mem_resp, a.lru_datain, a.pmem_read} !== 5'b1_110_0) begin
      n_fail++; $display("FAIL way2_update: got resp=%b lru=%b pmem_read=%b required 1/110/0",
                         a.mem_resp, a.lru_datain, a.pmem_read);
    end
    next_cycle();
    a.mem_read = 1'b0; a.s2_valid = 1'b0; a.s2_hit_vec = 4'h0;
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    next_cycle();
    b.mem_read = 1'b1; b.s2_valid = 1'b1; b.s2_plru = 7'b0000000; b.s2_hit_vec = 8'h20;
    b.s2_valid_vec = 8'hFF;
    sample();
    n_cmp++;
    if (b.mem_resp !== 1'b0) begin n_fail++; $display("FAIL b_idle_resp: got %b required 0", b.mem_resp); end
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      sample();
      if (b.mem_resp === 1'b1) cnt++;
      n_cmp++;
      if ({b.lru_load, b.lru_datain} !== 8'b1_0000100) begin
        n_fail++; $display("FAIL way5_update_%0d: got load=%b lru=%b required 1/0000100", i, b.lru_load, b.lru_datain);
      end
    end
    n_cmp++;
    if (cnt !== 10) begin n_fail++; $display("FAIL b2b_responses: got %0d required 10", cnt); end
    next_cycle();
    b.s2_plru = 7'b1111111; b.s2_hit_vec = 8'h08;
    sample();
    n_cmp++;
    if ({b.mem_resp, b.lru_datain} !== 8'b1_1101101) begin
      n_fail++; $display("FAIL way3_update: got resp=%b lru=%b required 1/1101101", b.mem_resp, b.lru_datain);
    end
    next_cycle();
    b.mem_read = 1'b0; b.s2_valid = 1'b0; b.s2_hit_vec = 8'h00;
    sample();
    n_cmp++;
    if (b.mem_resp !== 1'b0) begin n_fail++; $display("FAIL b_release: got %b required 0", b.mem_resp); end
  endtask

  task automatic test_flush();
    next_cycle();
    a.flush_req = 1'b1;
    sample();
    n_cmp++;
    if (a.flush_active !== 1'b0) begin n_fail++; $display("FAIL flush_idle_cycle: got %b required 0", a.flush_active); end
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      sample();
      n_cmp++;
      if ({a.flush_active, a.flush_index, a.way_load, a.valid_datain, a.lru_load, a.lru_datain,
           a.mem_resp, a.pmem_read, a.flush_done} !== {1'b1, 3'(i), 4'hF, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, (i == 7)}) begin
        n_fail++;
        $display("FAIL flush_step_%0d: got active=%b idx=%0d way_load=%b vdin=%b lru=%b/%b done=%b required 1/%0d/1111/0/1/000/%b",
                 i, a.flush_active, a.flush_index, a.way_load, a.valid_datain, a.lru_load, a.lru_datain,
                 a.flush_done, i, (i == 7));
      end
    end
    next_cycle();
    a.flush_req = 1'b0;
    sample();
    n_cmp++;
    if ({a.flush_active, a.flush_index, a.flush_done, a.way_load} !== 8'b0) begin
      n_fail++; $display("FAIL flush_exit: got active=%b idx=%0d done=%b way_load=%b required all zero",
                         a.flush_active, a.flush_index, a.flush_done, a.way_load);
    end
  endtask

  task automatic test_flush_mid_miss();
    next_cycle();
    a.mem_read = 1'b1; a.s2_valid = 1'b0; a.s2_valid_vec = 4'hF; a.s2_plru = 3'b000;
    next_cycle();
    a.s2_valid = 1'b1;
    next_cycle();
    a.s2_valid = 1'b0; a.flush_req = 1'b1;
    sample();
    n_cmp++;
    if ({a.pmem_read, a.flush_active} !== 2'b10) begin
      n_fail++; $display("FAIL flush_deferred_miss: got pmem_read=%b active=%b required 1/0", a.pmem_read, a.flush_active);
    end
    next_cycle();
    a.pmem_resp = 1'b1;
    sample();
    n_cmp++;
    if ({a.way_load, a.flush_active} !== 5'b0001_0) begin
      n_fail++; $display("FAIL flush_deferred_fill: got way_load=%b active=%b required 0001/0", a.way_load, a.flush_active);
    end
    next_cycle();
    a.pmem_resp = 1'b0; a.s2_valid = 1'b1; a.s2_hit_vec = 4'b0001;
    sample();
    n_cmp++;
    if ({a.mem_resp, a.flush_active} !== 2'b10) begin
      n_fail++; $display("FAIL flush_deferred_resp: got resp=%b active=%b required 1/0", a.mem_resp, a.flush_active);
    end
    next_cycle();
    a.mem_read = 1'b0; a.s2_valid = 1'b0; a.s2_hit_vec = 4'h0;
    sample();
    n_cmp++;
    if ({a.mem_resp, a.flush_active} !== 2'b00) begin
      n_fail++; $display("FAIL flush_after_lookup: got resp=%b active=%b required 0/0", a.mem_resp, a.flush_active);
    end
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      sample();
      n_cmp++;
      if ({a.flush_active, a.flush_index, a.flush_done} !== {1'b1, 3'(i), (i == 7)}) begin
        n_fail++; $display("FAIL deferred_flush_%0d: got active=%b idx=%0d done=%b required 1/%0d/%b",
                           i, a.flush_active, a.flush_index, a.flush_done, i, (i == 7));
      end
    end
    next_cycle();
    a.flush_req = 1'b0;
  endtask

  task automatic test_rst_mid_miss();
    next_cycle();
    a.mem_read = 1'b1; a.s2_valid = 1'b0; a.s2_valid_vec = 4'hF;
    next_cycle();
    a.s2_valid = 1'b1;
    next_cycle();
    a.s2_valid = 1'b0;
    next_cycle();
    rst = 1'b1;
    sample();
    n_cmp++;
    if (a.pmem_read !== 1'b1) begin n_fail++; $display("FAIL rst_cycle_pmem_read: got %b required 1", a.pmem_read); end
    next_cycle();
    rst = 1'b0; a.pmem_resp = 1'b1; a.mem_read = 1'b0;
    sample();
    n_cmp++;
    if ({a.mem_resp, a.pmem_read, a.way_load, a.valid_datain, a.lru_load, a.addr_sel, a.flush_active} !== '0) begin
      n_fail++; $display("FAIL rst_abandon: got pmem_read=%b way_load=%b addr_sel=%b required all zero",
                         a.pmem_read, a.way_load, a.addr_sel);
    end
    next_cycle();
    sample();
    n_cmp++;
    if ({a.way_load, a.pmem_read} !== 5'b0) begin
      n_fail++; $display("FAIL rst_late_resp: got way_load=%b pmem_read=%b required 0000/0", a.way_load, a.pmem_read);
    end
    a.pmem_resp = 1'b0;
  endtask

  initial begin
    a.mem_read = 1'b0; a.s2_valid = 1'b0; a.s2_hit_vec = '0; a.s2_valid_vec = '0;
    a.s2_plru = '0; a.pmem_resp = 1'b0; a.flush_req = 1'b0;
    b.mem_read = 1'b0; b.s2_valid = 1'b0; b.s2_hit_vec = '0; b.s2_valid_vec = '0;
    b.s2_plru = '0; b.pmem_resp = 1'b0; b.flush_req = 1'b0;
    test_reset();
    test_miss_plru();
    test_victim_invalid();
    test_back_to_back();
    test_flush();
    test_flush_mid_miss();
    test_rst_mid_miss();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
